// File: rtl/reg_file_pkg.sv
// Shared definitions for the integer register file and its optional debug dump.
// The dump logic is compiled in only when REG_FILE_DBG_EN is defined.
package reg_file_pkg;

    localparam int XLEN      = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        DUMP_IDLE,
        DUMP_STREAM
    } dump_state_t;

endpackage

// File: rtl/reg_file_dbg_dump.sv
// Debug dump engine: streams x0..x31 out over a valid/ready port, one beat per handshake.
// Reads the array through a bypassed port addressed at the next index to send.
module reg_file_dbg_dump
    import reg_file_pkg::*;
#(
    parameter int XLEN = reg_file_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dbg_start,
    input  logic                 dbg_ready,
    output logic [REG_IDX_W-1:0] rd_addr,
    input  logic [XLEN-1:0]      rd_data,
    output logic                 dbg_valid,
    output logic                 dbg_busy,
    output logic [REG_IDX_W-1:0] dbg_idx,
    output logic [XLEN-1:0]      dbg_data
);

    dump_state_t state;

    // Prefetch address: the value captured on a transfer belongs to the following index.
    assign rd_addr = dbg_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DUMP_IDLE;
            dbg_idx   <= '0;
            dbg_data  <= '0;
            dbg_valid <= 1'b0;
            dbg_busy  <= 1'b0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    if (dbg_start) begin
                        state     <= DUMP_STREAM;
                        dbg_idx   <= '0;
                        dbg_data  <= '0;
                        dbg_valid <= 1'b1;
                        dbg_busy  <= 1'b1;
                    end
                end
                DUMP_STREAM: begin
                    // Without ready the beat is frozen, so later writes cannot alter it.
                    if (dbg_ready) begin
                        if (dbg_idx == REG_IDX_W'(REG_COUNT - 1)) begin
                            state     <= DUMP_IDLE;
                            dbg_valid <= 1'b0;
                            dbg_busy  <= 1'b0;
                        end else begin
                            dbg_idx  <= rd_addr;
                            dbg_data <= rd_data;
                        end
                    end
                end
                default: state <= DUMP_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN register file with x0 hard-wired to zero and same-cycle write-back bypass.
// Defining REG_FILE_DBG_EN adds a streaming register dump on the dbg_* ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN = reg_file_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 wb_reg_write,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    input  logic                 dbg_start,
    output logic                 dbg_valid,
    input  logic                 dbg_ready,
    output logic [REG_IDX_W-1:0] dbg_idx,
    output logic [XLEN-1:0]      dbg_data,
    output logic                 dbg_busy
);

    logic [XLEN-1:0] regs [REG_COUNT];

    // NOTE: the array needs a real async clear here, so it is built from flops, not RAM.
    // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_reg_write && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // A write landing this cycle is forwarded so ID sees it without a stall.
    function automatic logic [XLEN-1:0] bypass_read(input logic [REG_IDX_W-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (wb_reg_write && wb_rd == addr) begin
            return wb_data;
        end else begin
            return regs[addr];
        end
    endfunction

    assign rs1_data = bypass_read(rs1_addr);
    assign rs2_data = bypass_read(rs2_addr);

`ifdef REG_FILE_DBG_EN
    logic [REG_IDX_W-1:0] dump_addr;
    logic [XLEN-1:0]      dump_data;

    assign dump_data = bypass_read(dump_addr);

    reg_file_dbg_dump #(
        .XLEN(XLEN)
    ) u_dbg_dump (
        .clk      (clk),
        .rst      (rst),
        .dbg_start(dbg_start),
        .dbg_ready(dbg_ready),
        .rd_addr  (dump_addr),
        .rd_data  (dump_data),
        .dbg_valid(dbg_valid),
        .dbg_busy (dbg_busy),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data)
    );
`else
    logic unused_dbg;
    assign unused_dbg = dbg_start ^ dbg_ready;

    assign dbg_valid = 1'b0;
    assign dbg_busy  = 1'b0;
    assign dbg_idx   = '0;
    assign dbg_data  = '0;
`endif

endmodule
